score_keeper_module: RTL



---
 rtl/score_keeper_module.sv | 139 +++++++++++++
 1 files changed

// File: rtl/score_keeper_module.sv
// score_keeper_module
// Turns line-clear events into level-weighted points, then rolls the displayed
// score up one point per video frame. Also tracks total lines and the level.
//
// state | meaning
// IDLE  | waiting for a line-clear event, clr_ready high
// COUNT | paying out pending points one per frame_tick, clr_ready low
module score_keeper_module #(
  parameter int SCORE_MAX       = 255,
  parameter int LINES_PER_LEVEL = 10,
  parameter int LEVEL_MAX       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       clr_valid,
  input  logic [2:0] clr_lines,
  output logic       clr_ready,
  input  logic       frame_tick,
  output logic [7:0] cur_score_bin,
  output logic       score_inc,
  output logic [7:0] lines_total,
  output logic [3:0] level
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [7:0] SCORE_MAX_L = 8'(SCORE_MAX);

  state_t     state_q, state_d;
  logic [6:0] pend_q, pend_d;
  logic [7:0] score_d;
  logic [7:0] lines_d;
  logic [3:0] level_d;
  logic       inc_d;

  logic       clr_legal;
  logic [3:0] base_pts;
  logic [7:0] award_full;
  logic [8:0] lines_sum;
  logic [7:0] lines_sat;
  logic [3:0] level_new;

  // Ready depends on the state register only, never on clr_valid.
  assign clr_ready = (state_q == IDLE);
  assign clr_legal = (clr_lines != 3'd0) && (clr_lines <= 3'd4);

  // Base points for the number of lines in the offered event.
  always_comb begin
    base_pts = 4'd0;
    case (clr_lines)
      3'd1:    base_pts = 4'd1;
      3'd2:    base_pts = 4'd3;
      3'd3:    base_pts = 4'd5;
      3'd4:    base_pts = 4'd8;
      default: base_pts = 4'd0;
    endcase
  end

  // Weighting uses the registered level, so a boundary-crossing clear gets the old level.
  assign award_full = {4'b0, base_pts} * ({4'b0, level} + 8'd1);
  assign lines_sum  = {1'b0, lines_total} + {6'b0, clr_lines};
  assign lines_sat  = lines_sum[8] ? 8'hFF : lines_sum[7:0];

  // Level from the updated line count, as a compare chain capped at LEVEL_MAX.
  always_comb begin
    level_new = 4'd0;
    for (int i = 1; i <= LEVEL_MAX; i++) begin
      if (int'(lines_sat) >= i * LINES_PER_LEVEL) level_new = 4'(i);
    end
  end

  // Next-state and next-value logic; game_start overrides everything.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    score_d = cur_score_bin;
    lines_d = lines_total;
    level_d = level;
    inc_d   = 1'b0;
    if (game_start) begin
      state_d = IDLE;
      pend_d  = 7'd0;
      score_d = 8'd0;
      lines_d = 8'd0;
      level_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Illegal line counts are consumed with no effect.
          if (clr_valid && clr_legal) begin
            pend_d  = award_full[6:0];
            lines_d = lines_sat;
            level_d = level_new;
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (cur_score_bin == SCORE_MAX_L) begin
            // Saturated: drop whatever is left and stop rolling.
            pend_d  = 7'd0;
            state_d = IDLE;
          end else if (pend_q == 7'd0) begin
            state_d = IDLE;
          end else if (frame_tick) begin
            score_d = cur_score_bin + 8'd1;
            pend_d  = pend_q - 7'd1;
            inc_d   = 1'b1;
            if (pend_q == 7'd1) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_q        <= 7'd0;
      cur_score_bin <= 8'd0;
      lines_total   <= 8'd0;
      level         <= 4'd0;
      score_inc     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      cur_score_bin <= score_d;
      lines_total   <= lines_d;
      level         <= level_d;
      score_inc     <= inc_d;
    end
  end

endmodule
